// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state codes, frame geometry and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-buffer handshake between the transmitter (master) and its FIFO (slave).
interface uart_tx_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = AW + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;

  modport master (output push, pop, wdata, input full, empty, rdata, level);
  modport slave  (input push, pop, wdata, output full, empty, rdata, level);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full buffer is only taken alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_tx_fifo_if.slave f
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign f.full  = (r_level == LW'(DEPTH));
  assign f.empty = (r_level == '0);
  assign f.level = r_level;
  assign f.rdata = r_mem[r_rptr];

  assign w_wr = f.push & (~f.full | f.pop);
  assign w_rd = f.pop & ~f.empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= f.wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: edge-detected byte strobe feeds a FIFO drained back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BPS   = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_en,
  input  logic [7:0] uart_data,
  output logic       uart_txd,
  output logic [3:0] tx_cnt,
  output logic       tx_busy,
  output logic [4:0] fifo_level,
  output logic       fifo_ovf
);
  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  logic              r_en_s1;
  logic              r_en_s2;
  logic              r_en_d;
  uart_state_e       r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [7:0]        r_shift;
  logic              r_txd;
  logic              r_busy;
  logic [3:0]        r_cnt;
  logic              r_ovf;
  logic              w_push;
  logic              w_pop;
  logic              w_baud_end;

  uart_tx_fifo_if #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo_if ();

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .f       (u_fifo_if)
  );

  assign w_push     = r_en_s2 & ~r_en_d;
  assign w_baud_end = (r_baud == BAUD_W'(BPS_CNT - 1));
  // Pop either from idle or on the last stop cycle so buffered frames abut.
  assign w_pop      = ~u_fifo_if.empty &
                      ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_end));

  assign u_fifo_if.push  = w_push;
  assign u_fifo_if.pop   = w_pop;
  assign u_fifo_if.wdata = uart_data;

  assign uart_txd   = r_txd;
  assign tx_cnt     = r_cnt;
  assign tx_busy    = r_busy;
  assign fifo_level = 5'(u_fifo_if.level);
  assign fifo_ovf   = r_ovf;

  // Strobe synchroniser, rising-edge detect and sticky overflow flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_en_s1 <= 1'b0;
      r_en_s2 <= 1'b0;
      r_en_d  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_en_s1 <= uart_en;
      r_en_s2 <= r_en_s1;
      r_en_d  <= r_en_s2;
      r_ovf   <= r_ovf | (w_push & u_fifo_if.full & ~w_pop);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_shift <= '0;
      r_txd   <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_START;
            r_shift <= u_fifo_if.rdata;
            r_txd   <= LINE_START;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_baud  <= '0;
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_state <= ST_DATA;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_cnt   <= r_cnt + 4'd1;
            r_baud  <= '0;
          end else begin
            r_baud  <= r_baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_cnt == 4'(DATA_BITS)) begin
              r_state <= ST_STOP;
              r_txd   <= LINE_STOP;
              r_cnt   <= 4'(FRAME_BITS - 1);
            end else begin
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_cnt   <= r_cnt + 4'd1;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            r_cnt  <= '0;
            if (w_pop) begin
              r_state <= ST_START;
              r_shift <= u_fifo_if.rdata;
              r_txd   <= LINE_START;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= LINE_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
